// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with in-order response FIFO and redirect drain
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode,
    output logic            err_spurious
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic [XLEN-1:0] req_addr_q, resp_pc_q, last_instr_q, last_pc_q, redirect_tgt;
    logic [CW-1:0]   outstanding_q, drop_q, count_q, outstanding_nxt, drop_nxt;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic            err_q, credit_ok, req_valid, hs, spurious, resp_ok, push, pop, fifo_nempty;

    assign redirect_tgt    = redirect_pc & ~XLEN'(3);
    // Requests in flight plus buffered words never exceed DEPTH, so a push always has room.
    assign credit_ok       = ({1'b0, outstanding_q} + {1'b0, count_q}) < CW1'(DEPTH);
    assign hs              = req_valid & imem_req_ready;
    assign spurious        = imem_resp_valid & (outstanding_q == '0);
    assign resp_ok         = imem_resp_valid & ~spurious;
    assign push            = resp_ok & ~redirect_valid & (drop_q == '0);
    assign fifo_nempty     = (count_q != '0);
    assign pop             = fifo_nempty & ~stall & ~redirect_valid;
    assign outstanding_nxt = outstanding_q + CW'(hs) - CW'(resp_ok);

    always_comb begin
        drop_nxt = drop_q;
        if (redirect_valid) begin
            drop_nxt = outstanding_nxt;
        end else if (resp_ok && (drop_q != '0)) begin
            drop_nxt = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: req_valid = credit_ok;
            S_DRAIN: if (drop_nxt == '0) state_nxt = S_FETCH;
            default: state_nxt = S_BOOT;
        endcase
        if (redirect_valid) begin
            state_nxt = (drop_nxt == '0) ? S_FETCH : S_DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            last_instr_q  <= NOP;
            last_pc_q     <= RESET_PC;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_nxt;
            drop_q        <= drop_nxt;
            if (spurious) begin
                err_q <= 1'b1;
            end
            if (redirect_valid) begin
                req_addr_q <= redirect_tgt;
                resp_pc_q  <= redirect_tgt;
            end else begin
                if (hs) req_addr_q <= req_addr_q + STEP;
                if (push) resp_pc_q <= resp_pc_q + STEP;
            end
            // Remember whatever decode last saw so the outputs hold once the FIFO empties.
            if (fifo_nempty) begin
                last_instr_q <= fifo_instr[rd_ptr_q];
                last_pc_q    <= fifo_pc[rd_ptr_q];
            end
            if (redirect_valid) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= imem_resp_data;
            fifo_pc[wr_ptr_q]    <= resp_pc_q;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = req_addr_q;
    assign if_valid       = fifo_nempty;
    assign if_instr       = fifo_nempty ? fifo_instr[rd_ptr_q] : last_instr_q;
    assign if_pc          = fifo_nempty ? fifo_pc[rd_ptr_q] : last_pc_q;
    assign if_opcode      = if_instr[6:0];
    assign err_spurious   = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic [6:0]  if_opcode;
    logic        err_spurious;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_opcode(if_opcode),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    pend_t       pend_q[$];
    exp_t        exp_q[$];
    logic [31:0] hs_q[$];
    logic [31:0] model_addr;
    bit          mem_hold;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 7) ^ 32'hC0DE_0000 ^ {25'b0, a[6:2], 2'b11};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge with inputs already set; advances one clock.
    task automatic cycle();
        bit    hs, rsp, pop;
        pend_t p;
        exp_t  e;
        #1;
        hs  = imem_req_valid && imem_req_ready;
        rsp = imem_resp_valid;
        pop = if_valid && !stall && !redirect_valid;
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_if_valid", {31'b0, if_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", if_pc, e.pc);
                chk("pop_instr", if_instr, e.instr);
                chk("pop_opcode", {25'b0, if_opcode}, {25'b0, e.instr[6:0]});
            end
        end
        if (rsp && pend_q.size() > 0) begin
            p = pend_q.pop_front();
            if (!p.stale && !redirect_valid) exp_q.push_back('{pc: p.addr, instr: mem_word(p.addr)});
        end
        if (hs) begin
            chk("req_addr", imem_req_addr, model_addr);
            hs_q.push_back(model_addr);
            pend_q.push_back('{addr: model_addr, stale: redirect_valid});
            model_addr = model_addr + 32'd4;
        end
        if (redirect_valid) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_q.delete();
            model_addr = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        if (!mem_hold && pend_q.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        mem_hold = 1'b0;
        pend_q.delete();
        exp_q.delete();
        hs_q.delete();
        model_addr = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        stall = 1'b0;
        imem_req_ready = 1'b0;
        mem_hold = 1'b0;
        for (int i = 0; i < 30 && (pend_q.size() != 0 || exp_q.size() != 0 || if_valid); i++) cycle();
        chk("drain_exp_empty", exp_q.size(), 32'd0);
        chk("drain_if_valid", {31'b0, if_valid}, 32'd0);
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        stall = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        mem_hold = 1'b0;
        model_addr = 32'h0;
        @(negedge clk);
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_opcode", {25'b0, if_opcode}, 32'h13);
        chk("rst_err", {31'b0, err_spurious}, 32'd0);

        // Streaming fetch, 1-cycle memory latency
        do_reset();
        chk("t1_boot_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cycle();
        chk("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        cycle();
        chk("t1_no_bypass", {31'b0, if_valid}, 32'd0);
        cycle();
        chk("t1_first_if_valid", {31'b0, if_valid}, 32'd1);
        chk("t1_first_if_pc", if_pc, 32'h0);
        repeat (8) cycle();
        for (int i = 0; i < 3; i++) chk("t1_hs_addr", (i < hs_q.size()) ? hs_q[i] : 32'bx, 32'(4 * i));
        drain();

        // Stall fills the credits
        do_reset();
        stall = 1'b1;
        repeat (6) cycle();
        chk("t2_hs_count", hs_q.size(), 32'd2);
        chk("t2_req_valid_off", {31'b0, imem_req_valid}, 32'd0);
        chk("t2_if_valid", {31'b0, if_valid}, 32'd1);
        chk("t2_if_pc_hold", if_pc, 32'h0);
        stall = 1'b0;
        for (int i = 0; i < 10 && hs_q.size() < 3; i++) cycle();
        chk("t2_resume_addr", (hs_q.size() >= 3) ? hs_q[2] : 32'bx, 32'h8);
        drain();

        // Backpressure on the request channel
        do_reset();
        cycle();
        cycle();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_valid_held", {31'b0, imem_req_valid}, 32'd1);
            chk("t3_addr_held", imem_req_addr, 32'h4);
            cycle();
        end
        chk("t3_hs_count", hs_q.size(), 32'd1);
        imem_req_ready = 1'b1;
        repeat (4) cycle();
        drain();

        // Redirect with two requests outstanding
        do_reset();
        mem_hold = 1'b1;
        repeat (3) cycle();
        chk("t4_credit_stop", {31'b0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        mem_hold       = 1'b0;
        cycle();
        waited = 0;
        while (!imem_req_valid && waited < 10) begin
            cycle();
            waited++;
        end
        chk("t4_drain_cycles", waited, 32'd2);
        chk("t4_redirect_addr", imem_req_addr, 32'h100);
        waited = 0;
        while (!if_valid && waited < 10) begin
            cycle();
            waited++;
        end
        chk("t4_first_pc", if_pc, 32'h100);
        repeat (3) cycle();
        drain();

        // Redirect together with a response and a handshake
        do_reset();
        cycle();
        cycle();
        chk("t5_hs_same_cycle", {31'b0, imem_req_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        chk("t5_flushed", {31'b0, if_valid}, 32'd0);
        chk("t5_draining", {31'b0, imem_req_valid}, 32'd0);
        cycle();
        chk("t5_still_empty", {31'b0, if_valid}, 32'd0);
        chk("t5_resume_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t5_resume_addr", imem_req_addr, 32'h200);
        repeat (4) cycle();
        drain();

        // Spurious response
        do_reset();
        imem_req_ready = 1'b0;
        cycle();
        cycle();
        chk("t6_err_before", {31'b0, err_spurious}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        cycle();
        chk("t6_err_set", {31'b0, err_spurious}, 32'd1);
        chk("t6_fifo_unchanged", {31'b0, if_valid}, 32'd0);
        chk("t6_instr_hold", if_instr, 32'h0000_0013);
        imem_req_ready = 1'b1;
        repeat (6) cycle();
        chk("t6_err_sticky", {31'b0, err_spurious}, 32'd1);
        drain();
        do_reset();
        chk("t6_err_cleared", {31'b0, err_spurious}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
